// File: rtl/fifo_reader_pkg.sv
// Shared defaults and types for the FIFO read-side master (fifo_reader).
package fifo_reader_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 5;
  localparam int STAT_W     = 16;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } rd_state_t;

endpackage

// File: rtl/fifo_reader_buf.sv
// Circular output buffer for fifo_reader; head/valid form the downstream byte stream.
module fifo_reader_buf
  import fifo_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [OCC_W-1:0]  occ,
  output logic [DATA_W-1:0] head,
  output logic              valid
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              pop_fire;

  // Pointers wrap at DEPTH explicitly so non-power-of-two depths also work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop_fire = pop && valid;
  assign valid    = (occ != '0);
  assign head     = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push)     wr_ptr <= ptr_inc(wr_ptr);
      if (pop_fire) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop_fire})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fifo_reader.sv
// Read-side master for a 16-entry byte FIFO with a valid/ready byte output.
// Optional pop/retry statistics ports are built when FIFO_READER_STATS_EN is defined.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [CNT_W-1:0]  fifo_cnt,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_re,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [STAT_W-1:0] pop_count,
  output logic [STAT_W-1:0] retry_count
`endif
);

  localparam int OCC_W = $clog2(OUT_DEPTH + 1);

  rd_state_t        state;
  rd_state_t        next_state;
  logic [CNT_W-1:0] cnt_snap;
  logic [OCC_W-1:0] occ;
  logic             pend;
  logic             accept;

  // The FIFO favours writes, so a pop only took effect if the count dropped by exactly one.
  assign pend   = (state == PEND);
  assign accept = pend && (fifo_cnt == CNT_W'(cnt_snap - CNT_W'(1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt_snap <= '0;
    end else begin
      state <= next_state;
      if (fifo_re) cnt_snap <= fifo_cnt;
    end
  end

  always_comb begin
    fifo_re    = 1'b0;
    next_state = IDLE;
    if (rst && !fifo_empty && ((int'(occ) + int'(pend)) < OUT_DEPTH)) begin
      fifo_re    = 1'b1;
      next_state = PEND;
    end
  end

  fifo_reader_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (OUT_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .din   (fifo_dout),
    .pop   (out_ready),
    .occ   (occ),
    .head  (out_data),
    .valid (out_valid)
  );

`ifdef FIFO_READER_STATS_EN
  logic refuse;

  assign refuse = pend && !accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pop_count   <= '0;
      retry_count <= '0;
    end else begin
      if (accept && (pop_count != '1))   pop_count   <= pop_count + STAT_W'(1);
      if (refuse && (retry_count != '1)) retry_count <= retry_count + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a write-priority 16-entry FIFO model feeds the DUT and
// the output stream is checked against the order of bytes written into that FIFO.
`timescale 1ns/1ps
module tb_fifo_reader;

  localparam int DATA_W     = 8;
  localparam int CNT_W      = 5;
  localparam int OUT_DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_re;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
`ifdef FIFO_READER_STATS_EN
  logic [15:0]       pop_count;
  logic [15:0]       retry_count;
`endif

  logic              wr_en;
  logic [7:0]        wr_data;

  int                checks;
  int                errors;
  int                rd_idx;
  int                xfer_total;
  bit                prev_hold;
  logic [7:0]        prev_data;
  int unsigned       wr_pcts [4] = '{30, 90, 60, 10};
  int unsigned       rdy_pcts[4] = '{90, 20, 60, 100};

  always #5 clk = ~clk;

  fifo_reader #(
    .DATA_W    (DATA_W),
    .CNT_W     (CNT_W),
    .OUT_DEPTH (OUT_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_cnt   (fifo_cnt),
    .fifo_dout  (fifo_dout),
    .fifo_re    (fifo_re),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
`ifdef FIFO_READER_STATS_EN
    ,
    .pop_count   (pop_count),
    .retry_count (retry_count)
`endif
  );

  // Environment FIFO: registered count/data, write wins over a same-cycle read.
  logic [7:0] fifo_mem [16];
  logic [3:0] fifo_rp;
  logic [3:0] fifo_wp;
  logic [4:0] cnt_q;
  logic [7:0] dout_q;
  int         acc_total;
  bit         saw_full_accept;
  logic [7:0] exp_q [$];
`ifdef FIFO_READER_STATS_EN
  int         acc_lag;
  int         ref_total;
  int         ref_lag;
`endif

  assign fifo_cnt   = cnt_q;
  assign fifo_empty = (cnt_q == 5'd0);
  assign fifo_dout  = dout_q;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q           <= 5'd0;
      fifo_rp         <= 4'd0;
      fifo_wp         <= 4'd0;
      dout_q          <= 8'd0;
      acc_total       <= 0;
      saw_full_accept <= 1'b0;
`ifdef FIFO_READER_STATS_EN
      acc_lag         <= 0;
      ref_total       <= 0;
      ref_lag         <= 0;
`endif
      exp_q.delete();
    end else begin
`ifdef FIFO_READER_STATS_EN
      acc_lag <= acc_total;
      ref_lag <= ref_total;
      if (fifo_re && (wr_en || cnt_q == 5'd0)) ref_total <= ref_total + 1;
`endif
      if (wr_en) begin
        fifo_mem[fifo_wp] <= wr_data;
        fifo_wp           <= fifo_wp + 4'd1;
        cnt_q             <= cnt_q + 5'd1;
        exp_q.push_back(wr_data);
      end else if (fifo_re && cnt_q != 5'd0) begin
        dout_q    <= fifo_mem[fifo_rp];
        fifo_rp   <= fifo_rp + 4'd1;
        cnt_q     <= cnt_q - 5'd1;
        acc_total <= acc_total + 1;
        if (cnt_q == 5'd16) saw_full_accept <= 1'b1;
      end
    end
  end

  task automatic check_output(input bit ok, input string name,
                              input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the ordered-stream model.
  task automatic compare_cycle();
    int held;
    logic [31:0] want;
    if (rst !== 1'b1) return;
    if (fifo_re) check_output(fifo_empty == 1'b0, "re_when_empty", 32'(fifo_empty), 32'd0);
    if (prev_hold) begin
      check_output(out_valid == 1'b1, "hold_valid", 32'(out_valid), 32'd1);
      check_output(out_data == prev_data, "hold_data", 32'(out_data), 32'(prev_data));
    end
    held = acc_total - xfer_total;
    check_output(held >= 0 && held <= OUT_DEPTH, "buffer_bound", 32'(held), 32'(OUT_DEPTH));
    if (out_valid && out_ready) begin
      want = (rd_idx < exp_q.size()) ? 32'(exp_q[rd_idx]) : 32'hFFFF_FFFF;
      check_output(rd_idx < exp_q.size() && out_data == exp_q[rd_idx], "stream_byte",
                   32'(out_data), want);
      rd_idx++;
      xfer_total++;
    end
`ifdef FIFO_READER_STATS_EN
    check_output(pop_count == 16'(acc_lag), "pop_count", 32'(pop_count), 32'(acc_lag));
    check_output(retry_count == 16'(ref_lag), "retry_count", 32'(retry_count), 32'(ref_lag));
`endif
    prev_hold = out_valid && !out_ready;
    prev_data = out_data;
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && rd_idx < exp_q.size(); i++) tick();
    check_output(rd_idx == exp_q.size(), "drain_complete", 32'(rd_idx), 32'(exp_q.size()));
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: no completion, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_data = 8'd0; out_ready = 1'b0;
    checks = 0; errors = 0; rd_idx = 0; xfer_total = 0;
    prev_hold = 1'b0; prev_data = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check_output(fifo_re == 1'b0, "reset_re", 32'(fifo_re), 32'd0);
    check_output(out_valid == 1'b0, "reset_valid", 32'(out_valid), 32'd0);
    check_output(out_data == 8'd0, "reset_data", 32'(out_data), 32'd0);
`ifdef FIFO_READER_STATS_EN
    check_output(pop_count == 16'd0, "reset_pop_count", 32'(pop_count), 32'd0);
    check_output(retry_count == 16'd0, "reset_retry_count", 32'(retry_count), 32'd0);
`endif
    rst = 1'b1;
    out_ready = 1'b1;
    tick();

    // Drain: three bytes stream out back to back, 2 cycles after the first honoured pop.
    apply_stimulus(8'h11); apply_stimulus(8'h22); apply_stimulus(8'h33);
    wr_en = 1'b0;
    check_output(fifo_re == 1'b1, "drain_issue", 32'(fifo_re), 32'd1);
    check_output(out_valid == 1'b0, "drain_lat0", 32'(out_valid), 32'd0);
    tick();
    check_output(out_valid == 1'b0, "drain_lat1", 32'(out_valid), 32'd0);
    tick();
    check_output(out_valid && out_data == 8'h11, "drain_b0", 32'(out_data), 32'h11);
    tick();
    check_output(out_valid && out_data == 8'h22, "drain_b1", 32'(out_data), 32'h22);
    tick();
    check_output(out_valid && out_data == 8'h33, "drain_b2", 32'(out_data), 32'h33);
    tick();
    check_output(out_valid == 1'b0, "drain_end", 32'(out_valid), 32'd0);
`ifdef FIFO_READER_STATS_EN
    check_output(pop_count == 16'd3, "drain_pop_count", 32'(pop_count), 32'd3);
`endif

    // Competing writes: every pop is refused while the FIFO is being written.
    apply_stimulus(8'h01);
    for (int i = 0; i < 8; i++) apply_stimulus(8'hA0);
    wr_en = 1'b0;
    check_output(out_valid == 1'b0, "compete_no_output", 32'(out_valid), 32'd0);
`ifdef FIFO_READER_STATS_EN
    check_output(pop_count == 16'd3, "compete_pop_count", 32'(pop_count), 32'd3);
`endif
    wait_drain(100);

    // Backpressure: the buffer fills to OUT_DEPTH and the reader stops popping.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) apply_stimulus(8'(48 + i));
    wr_en = 1'b0;
    repeat (8) tick();
    check_output(fifo_re == 1'b0, "bp_re", 32'(fifo_re), 32'd0);
    check_output(fifo_cnt == 5'd6, "bp_cnt", 32'(fifo_cnt), 32'd6);
    check_output(out_valid && out_data == 8'h30, "bp_head", 32'(out_data), 32'h30);
    repeat (4) tick();
    check_output(out_data == 8'h30, "bp_head_stable", 32'(out_data), 32'h30);
    out_ready = 1'b1;
    wait_drain(100);

    // Full FIFO and buffer wrap.
    for (int i = 0; i < 16; i++) apply_stimulus(8'(128 + i));
    wr_en = 1'b0;
    check_output(fifo_cnt == 5'd16, "full_cnt", 32'(fifo_cnt), 32'd16);
    wait_drain(100);
    check_output(saw_full_accept == 1'b1, "full_snapshot_accept", 32'(saw_full_accept), 32'd1);

    // Reset in PEND with two bytes buffered.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) apply_stimulus(8'(192 + i));
    wr_en = 1'b0;
    repeat (3) tick();
    check_output(out_valid && out_data == 8'hC0, "pre_reset_head", 32'(out_data), 32'hC0);
    #2 rst = 1'b0;
    #1;
    check_output(fifo_re == 1'b0, "async_reset_re", 32'(fifo_re), 32'd0);
    check_output(out_valid == 1'b0, "async_reset_valid", 32'(out_valid), 32'd0);
    check_output(out_data == 8'd0, "async_reset_data", 32'(out_data), 32'd0);
`ifdef FIFO_READER_STATS_EN
    check_output(pop_count == 16'd0, "async_reset_pops", 32'(pop_count), 32'd0);
    check_output(retry_count == 16'd0, "async_reset_retries", 32'(retry_count), 32'd0);
`endif
    rd_idx = 0; xfer_total = 0; prev_hold = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    out_ready = 1'b1;
    apply_stimulus(8'h55);
    wr_en = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    check_output(out_valid && out_data == 8'h55, "post_reset_first", 32'(out_data), 32'h55);
    wait_drain(50);

    // Randomised traffic with varying write and ready densities.
    for (int phase = 0; phase < 4; phase++) begin
      for (int c = 0; c < 400; c++) begin
        wr_en     = (cnt_q < 5'd16) && ($urandom_range(0, 99) < wr_pcts[phase]);
        wr_data   = 8'($urandom);
        out_ready = ($urandom_range(0, 99) < rdy_pcts[phase]);
        tick();
      end
    end
    wr_en = 1'b0;
    out_ready = 1'b1;
    wait_drain(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

- Read-side master for the 16-entry byte FIFO.
- Polls `fifo_empty`, drives `fifo_re` and detects whether each pop was honoured by watching `fifo_cnt`; the FIFO gives a write priority over a read in the same cycle.
- Captures `fifo_dout` for each accepted pop into a small output buffer, presented downstream as a valid/ready byte stream.
- Sits between the FIFO and any byte consumer (serializer, checker, bus bridge).

## Interface
- `DATA_W`, 8, FIFO data width.
- `CNT_W`, 5, width of the FIFO occupancy count (0..16).
- `OUT_DEPTH`, 4, output buffer entries; minimum 3 for one byte/cycle throughput.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_cnt`  in  CNT_W  FIFO occupancy, registered in the FIFO.
- `fifo_dout`  in  DATA_W  FIFO read data, registered; valid the cycle after an accepted pop.
- `fifo_re`  out  1  pop request to the FIFO.
- `out_valid`  out  1  `out_data` holds a byte.
- `out_ready`  in  1  consumer accepts the byte.
- `out_data`  out  DATA_W  head of the output buffer.
- `pop_count`  out  16  accepted pops; present only with `FIFO_READER_STATS_EN`.
- `retry_count`  out  16  refused pops; present only with `FIFO_READER_STATS_EN`.

## Operation
- **Tracker FSM:** IDLE (no pop in flight) and PEND (one pop issued last cycle). At most one pop is in flight.
- **Issue rule:** `fifo_re` = `!fifo_empty && (occ + pend) < OUT_DEPTH`.
  - `occ` is the buffer occupancy and `pend` is 1 in PEND.
  - The rule is combinational from registers and `fifo_empty` only; there is no path from `out_ready` to `fifo_re`.
- **On issue:** latch `cnt_snap <= fifo_cnt`; next state is PEND. Without an issue, next state is IDLE.
- **In PEND, accept vs. refuse:**
  - Pop accepted iff `fifo_cnt == cnt_snap - 1`, computed as CNT_W-bit subtraction.
  - Accepted: push `fifo_dout` into the buffer.
  - Any other value (cnt_snap+1 from a competing write, or unchanged) means refused: push nothing and increment `retry_count`.
  - A new issue may occur in the same PEND cycle (back-to-back pops).
- **Output buffer:** circular, OUT_DEPTH entries.
  - Pop when `out_valid && out_ready`.
  - Push and pop in the same cycle leave `occ` unchanged.
  - Read and write pointers wrap modulo OUT_DEPTH.
- **Order:** byte order out equals FIFO order. No byte is duplicated or dropped, including under refusals.
- **FIFO full:** the reader does not care; `fifo_cnt` = 16 is simply a valid snapshot (16 → 15 means accepted).
- **Reset:** whenever `rst` is low, state goes to IDLE, `occ` = 0, pointers = 0 and counters = 0. An in-flight pop is discarded. The system resets the FIFO in the same window.
- **Counters:** saturate at 16'hFFFF.

## Timing
- **Reset values:** `fifo_re` = 0 while `rst` is low, `out_valid` = 0, `out_data` = 0, `pop_count` = 0, `retry_count` = 0.
- **Latency:**
  - Issue in cycle N; FIFO updates at edge N.
  - Accept/refuse decision in cycle N+1; byte written at edge N+1.
  - `out_valid` high in cycle N+2.
- **Minimum latency** from FIFO non-empty to `out_valid` is 2 cycles.
- **Throughput:** one byte per cycle with no competing writes and `out_ready` held high.
- **Stream handshake:**
  - `out_data` and `out_valid` are stable while `out_valid && !out_ready`.
  - `out_valid` never drops without a transfer.
- **Refusal:** costs one cycle. Reissue happens in the decision cycle if the issue rule still holds.

## Configuration
- **`FIFO_READER_STATS_EN` defined:** `pop_count` and `retry_count` ports and counters exist.
- **Not defined:** the ports and logic are absent. Datapath behaviour is identical either way.

## Structure
- **Package `fifo_reader_pkg`:**
  - `DATA_W`/`CNT_W` defaults.
  - `rd_state_t` enum {IDLE, PEND}.
  - Stats counter width localparam.
- **Sub-module `fifo_reader_buf`:** the OUT_DEPTH circular output buffer with `push`, `pop`, `occ`, `head` and `valid`. The top level holds the tracker and the issue rule.

## Test plan
- **Drain:** write 0x11, 0x22, 0x33 into the FIFO, then start the reader with `out_ready` = 1 → stream 0x11, 0x22, 0x33 in consecutive cycles; the first byte has `out_valid` 2 cycles after the first `fifo_re`; `pop_count` = 3.
- **Competing write:** write 0xA0 every cycle while the reader pops with 1 byte preloaded → reads refused, `retry_count` increments each cycle; after writes stop, bytes emerge in order with no duplicate or loss.
- **Backpressure:** preload 10 bytes, `out_ready` = 0 → exactly OUT_DEPTH (4) pops, then `fifo_re` = 0 with `fifo_cnt` = 6; `out_data` stable; release → remaining bytes in order.
- **Full and wrap:** fill the FIFO to 16 (`fifo_cnt` = 16), drain all → the 16 → 15 snapshot is accepted; all 16 bytes out in order; the buffer pointers have wrapped.
- **Reset mid-operation:** assert `rst` low in PEND with 2 bytes buffered → `fifo_re`, `out_valid` and counters are 0 asynchronously; after release and a FIFO refill of 0x55, the first output is 0x55.
